fuzz_stim_sequencer: RTL and testbench
======================================

Name: fuzz_stim_sequencer

Overview:
- Hardware replacement for the LCG stimulus loop in the fuzz benches.
- Seeded 32-bit LCG fills a wide stimulus vector one 32-bit word per clock.
- Offers the vector to the DUT-side consumer over a valid/ready handshake and repeats for a programmed cycle count.
- Sits between the run controller (start/seed/cycles) and the DUT `in_flat` input register.

Parameters:
- NUM_WORDS, 8, number of 32-bit words per vector (vector width = NUM_WORDS*32).
- CNT_W, 32, width of the cycle count and the vector index.
- LCG_MUL, 32'h41C64E6D, LCG multiplier.
- LCG_INC, 32'h00003039, LCG increment.

Ports:
- clk  input  1  system clock, all logic on posedge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  single-cycle run request; sampled only in IDLE.
- seed  input  32  initial LCG state; latched on accepted start.
- cycles  input  CNT_W  run length; latched on accepted start.
- vec_valid  output  1  vec_data holds a complete vector.
- vec_ready  input  1  consumer accepts the vector when high with vec_valid.
- vec_data  output  NUM_WORDS*32  stimulus vector; word k at bits [32k+31:32k].
- vec_idx  output  CNT_W  index of the vector currently offered (0-based).
- busy  output  1  high in every state except IDLE.
- done  output  1  one-cycle pulse when the run completes.

Behaviour:
- Reset (asynchronous, takes effect mid-operation): FSM goes to IDLE. LCG state, latched cycles, word counter, vec_data, vec_idx, vec_valid, busy and done all clear to 0.
- LCG step: next = (state*LCG_MUL + LCG_INC) mod 2^32. Use the 32-bit truncated product; there is no carry beyond bit 31.
- Total vectors per run = cycles+1: one initial vector, then one per cycle.
- FSM states are IDLE, FILL, PRESENT, DONE.
- IDLE:
  - On start=1, latch seed and cycles, clear vec_idx, clear the word counter, go to FILL.
  - start in any other state is ignored and not queued.
- FILL:
  - Each cycle: state <= next; word[k] <= next; k++. Word 0 is written first.
  - After word NUM_WORDS-1 is written, go to PRESENT. Fill latency is exactly NUM_WORDS cycles.
  - vec_valid=0 throughout FILL.
- PRESENT:
  - vec_valid=1. vec_data and vec_idx must stay stable while vec_ready=0, with no bound on the stall.
  - On vec_valid&&vec_ready:
    - If vec_idx == latched cycles, go to DONE.
    - Otherwise vec_idx++, k=0, go to FILL.
  - vec_valid drops the cycle after the handshake.
- DONE: assert done for one cycle, then go to IDLE.
- vec_data retains the last vector after DONE until the next FILL overwrites it word by word.
- cycles=0: exactly one vector is produced, then DONE.
- cycles = 2^CNT_W-1: vec_idx reaches its maximum. The comparison with latched cycles ends the run, so vec_idx never wraps.
- start and handshake asserted in the same cycle: in PRESENT, start is ignored.
- The same seed always produces a bit-identical vector sequence.

Decomposition:
- Package fuzz_stim_pkg holds:
  - LCG_MUL_DEF and LCG_INC_DEF constants.
  - The state enum (IDLE, FILL, PRESENT, DONE).
  - The WORD_W=32 constant.
  - Function lcg_next(logic [31:0]).
- One sub-module, lcg32_step: a purely combinational next-state calculator, parameterised by MUL/INC and instantiated once.

Test Plan:
- Word values: seed=0, cycles=0, vec_ready=1 → vec_idx=0, word0=32'h00003039, word1=32'hD3DC167E; done pulses once; busy returns to 0.
- Handshake latency: seed=0, cycles=2, vec_ready=1 → three handshakes with vec_idx 0,1,2. Each vec_valid rises exactly NUM_WORDS cycles after FILL entry. Word0 of vector 1 equals lcg_next applied to word7 of vector 0.
- Backpressure: hold vec_ready=0 for 20 cycles in PRESENT → vec_valid, vec_data and vec_idx stay unchanged; releasing ready completes exactly one handshake.
- Start while busy: assert start with a different seed during FILL and during PRESENT → ignored; the output sequence matches the original seed.
- Reset mid-run: deassert rst_n during FILL word 3, asynchronously → all outputs 0 immediately. A restart with the same seed reproduces word0=32'h00003039 for seed 0.
- Reference compare: seed=3965395580, cycles=100 → 101 vectors match a software LCG model bit-for-bit; done pulses once.

Source files
------------

// File: rtl/fuzz_stim_pkg.sv
// Shared constants, FSM state type and reference LCG step for the fuzz stimulus sequencer.
package fuzz_stim_pkg;

    localparam int          WORD_W      = 32;
    localparam logic [31:0] LCG_MUL_DEF = 32'h41C64E6D;
    localparam logic [31:0] LCG_INC_DEF = 32'h00003039;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        FILL    = 2'd1,
        PRESENT = 2'd2,
        DONE    = 2'd3
    } state_e;

    // Product is deliberately truncated to 32 bits: the LCG runs mod 2^32.
    function automatic logic [31:0] lcg_next(input logic [31:0] state);
        return state * LCG_MUL_DEF + LCG_INC_DEF;
    endfunction

endpackage

// File: rtl/fuzz_stim_sequencer_if.sv
// Vector stream from the sequencer to the DUT-side input register (valid/ready).
interface fuzz_stim_sequencer_if #(
    parameter int NUM_WORDS = 8,
    parameter int CNT_W     = 32
);
    logic                      vec_valid;
    logic                      vec_ready;
    logic [NUM_WORDS*32-1:0]   vec_data;
    logic [CNT_W-1:0]          vec_idx;

    modport master (output vec_valid, output vec_data, output vec_idx, input  vec_ready);
    modport slave  (input  vec_valid, input  vec_data, input  vec_idx, output vec_ready);
endinterface

// File: rtl/fuzz_stim_sequencer_lcg32_step.sv
// Combinational single step of a 32-bit LCG: next = state*MUL + INC (mod 2^32).
module lcg32_step #(
    parameter logic [31:0] MUL = 32'h41C64E6D,
    parameter logic [31:0] INC = 32'h00003039
) (
    input  logic [31:0] state_i,
    output logic [31:0] next_o
);

    // Truncated product and sum, no carry kept past bit 31.
    always_comb begin
        next_o = state_i * MUL + INC;
    end

endmodule

// File: rtl/fuzz_stim_sequencer.sv
// Seeded LCG stimulus generator: fills a NUM_WORDS-word vector one word per clock and offers it over valid/ready.
module fuzz_stim_sequencer
    import fuzz_stim_pkg::*;
#(
    parameter int          NUM_WORDS = 8,
    parameter int          CNT_W     = 32,
    parameter logic [31:0] LCG_MUL   = LCG_MUL_DEF,
    parameter logic [31:0] LCG_INC   = LCG_INC_DEF
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         start,
    input  logic [31:0]                  seed,
    input  logic [CNT_W-1:0]             cycles,
    fuzz_stim_sequencer_if.master        vec_if,
    output logic                         busy,
    output logic                         done
);

    localparam int WCNT_W = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
    localparam int VEC_W  = NUM_WORDS * WORD_W;
    localparam logic [WCNT_W-1:0] LAST_WORD = WCNT_W'(NUM_WORDS - 1);

    state_e              state_q,     state_d;
    logic [31:0]         lcg_q,       lcg_d;
    logic [CNT_W-1:0]    cycles_q,    cycles_d;
    logic [WCNT_W-1:0]   wcnt_q,      wcnt_d;
    logic [VEC_W-1:0]    vec_data_q,  vec_data_d;
    logic [CNT_W-1:0]    vec_idx_q,   vec_idx_d;
    logic                vec_valid_q, vec_valid_d;
    logic                busy_q,      busy_d;
    logic                done_q,      done_d;
    logic [31:0]         lcg_step_s;

    lcg32_step #(
        .MUL (LCG_MUL),
        .INC (LCG_INC)
    ) u_lcg (
        .state_i (lcg_q),
        .next_o  (lcg_step_s)
    );

    // Next-state and datapath update; outputs are registered from the next state.
    always_comb begin
        state_d    = state_q;
        lcg_d      = lcg_q;
        cycles_d   = cycles_q;
        wcnt_d     = wcnt_q;
        vec_data_d = vec_data_q;
        vec_idx_d  = vec_idx_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    lcg_d     = seed;
                    cycles_d  = cycles;
                    vec_idx_d = {CNT_W{1'b0}};
                    wcnt_d    = {WCNT_W{1'b0}};
                    state_d   = FILL;
                end else begin
                    state_d   = IDLE;
                end
            end
            FILL: begin
                lcg_d = lcg_step_s;
                for (int k = 0; k < NUM_WORDS; k++) begin
                    if (wcnt_q == WCNT_W'(k)) begin
                        vec_data_d[k*WORD_W +: WORD_W] = lcg_step_s;
                    end else begin
                        vec_data_d[k*WORD_W +: WORD_W] = vec_data_q[k*WORD_W +: WORD_W];
                    end
                end
                if (wcnt_q == LAST_WORD) begin
                    wcnt_d  = {WCNT_W{1'b0}};
                    state_d = PRESENT;
                end else begin
                    wcnt_d  = wcnt_q + WCNT_W'(1);
                    state_d = FILL;
                end
            end
            PRESENT: begin
                // Comparing against the latched count ends the run before vec_idx can wrap.
                if (vec_valid_q && vec_if.vec_ready) begin
                    if (vec_idx_q == cycles_q) begin
                        state_d   = DONE;
                    end else begin
                        vec_idx_d = vec_idx_q + CNT_W'(1);
                        wcnt_d    = {WCNT_W{1'b0}};
                        state_d   = FILL;
                    end
                end else begin
                    state_d = PRESENT;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        vec_valid_d = (state_d == PRESENT);
        busy_d      = (state_d != IDLE);
        done_d      = (state_d == DONE);
    end

    // State and output registers with asynchronous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            lcg_q       <= 32'h0000_0000;
            cycles_q    <= {CNT_W{1'b0}};
            wcnt_q      <= {WCNT_W{1'b0}};
            vec_data_q  <= {VEC_W{1'b0}};
            vec_idx_q   <= {CNT_W{1'b0}};
            vec_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            lcg_q       <= lcg_d;
            cycles_q    <= cycles_d;
            wcnt_q      <= wcnt_d;
            vec_data_q  <= vec_data_d;
            vec_idx_q   <= vec_idx_d;
            vec_valid_q <= vec_valid_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign vec_if.vec_valid = vec_valid_q;
    assign vec_if.vec_data  = vec_data_q;
    assign vec_if.vec_idx   = vec_idx_q;
    assign busy             = busy_q;
    assign done             = done_q;

endmodule

// File: tb/tb_fuzz_stim_sequencer.sv
// Scoreboard bench for fuzz_stim_sequencer: expected vectors come from an independent LCG model.
module tb_fuzz_stim_sequencer;

    localparam int NW    = 8;
    localparam int CW    = 32;
    localparam int VW    = NW * 32;

    typedef struct {
        logic [CW-1:0] idx;
        logic [VW-1:0] data;
    } exp_t;

    logic          clk;
    logic          rst_n;
    logic          start;
    logic [31:0]   seed;
    logic [CW-1:0] cycles;
    logic          busy;
    logic          done;

    int   chk_cnt  = 0;
    int   err_cnt  = 0;
    int   hs_cnt   = 0;
    int   done_cnt = 0;
    int   fill_len = 0;
    logic prev_valid = 1'b0;
    bit   rdy_rand = 1'b0;
    exp_t sb_q[$];

    fuzz_stim_sequencer_if #(.NUM_WORDS(NW), .CNT_W(CW)) vif ();

    fuzz_stim_sequencer #(.NUM_WORDS(NW), .CNT_W(CW)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .seed   (seed),
        .cycles (cycles),
        .vec_if (vif.master),
        .busy   (busy),
        .done   (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [VW-1:0] obs, input logic [VW-1:0] exp);
        chk_cnt++;
        if (obs !== exp) begin
            err_cnt++;
            $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] model_lcg(input logic [31:0] s);
        logic [63:0] p;
        p = {32'h0, s} * 64'h0000_0000_41C6_4E6D + 64'h0000_0000_0000_3039;
        return p[31:0];
    endfunction

    task automatic push_run(input logic [31:0] s0, input logic [CW-1:0] n);
        logic [31:0] s;
        exp_t e;
        s = s0;
        for (int v = 0; v <= int'(n); v++) begin
            e.idx = CW'(v);
            for (int w = 0; w < NW; w++) begin
                s = model_lcg(s);
                e.data[w*32 +: 32] = s;
            end
            sb_q.push_back(e);
        end
    endtask

    task automatic pulse_start(input logic [31:0] s, input logic [CW-1:0] n);
        push_run(s, n);
        seed   = s;
        cycles = n;
        start  = 1'b1;
        @(posedge clk); #1;
        start  = 1'b0;
    endtask

    task automatic wait_valid(input int budget);
        int t;
        t = 0;
        while (!vif.vec_valid && t < budget) begin
            @(posedge clk); #1;
            t++;
        end
        if (!vif.vec_valid) chk("valid_timeout", 1'b0, 1'b1);
    endtask

    task automatic wait_done(input int budget);
        int d0;
        int t;
        bit ok;
        d0 = done_cnt;
        ok = 1'b0;
        for (t = 0; t < budget; t++) begin
            if (rdy_rand) vif.vec_ready = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
            if (done_cnt > d0 && !busy) begin
                ok = 1'b1;
                break;
            end
        end
        chk("done_timeout", VW'(ok), VW'(1));
        chk("done_pulses", VW'(done_cnt - d0), VW'(1));
        chk("busy_after", VW'(busy), VW'(0));
        chk("sb_empty", VW'(sb_q.size()), VW'(0));
    endtask

    // Negedge monitor: scoreboard pops on handshakes, fill latency and done pulses.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (done) done_cnt++;
            if (!busy) begin
                fill_len = 0;
            end else if (vif.vec_valid && !prev_valid) begin
                chk("fill_lat", VW'(fill_len), VW'(NW));
                fill_len = 0;
            end else if (!vif.vec_valid && !done) begin
                fill_len++;
            end
            prev_valid = vif.vec_valid;
            if (vif.vec_valid && vif.vec_ready) begin
                hs_cnt++;
                if (sb_q.size() == 0) begin
                    chk("unexpected_hs", 1'b1, 1'b0);
                end else begin
                    e = sb_q.pop_front();
                    chk("vec_idx", VW'(vif.vec_idx), VW'(e.idx));
                    chk("vec_data", vif.vec_data, e.data);
                end
            end
        end
    end

    initial begin
        int hs0;
        rst_n         = 1'b0;
        start         = 1'b0;
        seed          = 32'h0;
        cycles        = {CW{1'b0}};
        vif.vec_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid", VW'(vif.vec_valid), VW'(0));
        chk("rst_busy", VW'(busy), VW'(0));
        chk("rst_done", VW'(done), VW'(0));
        chk("rst_data", vif.vec_data, {VW{1'b0}});
        chk("rst_idx", VW'(vif.vec_idx), VW'(0));
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Known word values for seed 0, single vector.
        vif.vec_ready = 1'b1;
        pulse_start(32'h0, 32'd0);
        wait_done(100);
        chk("w0_seed0", VW'(vif.vec_data[31:0]), VW'(32'h00003039));
        chk("w1_seed0", VW'(vif.vec_data[63:32]), VW'(32'hD3DC167E));
        chk("idx_last", VW'(vif.vec_idx), VW'(0));

        // Three back-to-back vectors.
        pulse_start(32'h0, 32'd2);
        wait_done(200);

        // Backpressure: 20-cycle stall, then a single-cycle ready.
        vif.vec_ready = 1'b0;
        pulse_start(32'd5, 32'd1);
        wait_valid(40);
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            chk("stall_valid", VW'(vif.vec_valid), VW'(1));
            chk("stall_idx", VW'(vif.vec_idx), VW'(sb_q[0].idx));
            chk("stall_data", vif.vec_data, sb_q[0].data);
        end
        hs0 = hs_cnt;
        vif.vec_ready = 1'b1;
        @(posedge clk); #1;
        vif.vec_ready = 1'b0;
        chk("one_hs", VW'(hs_cnt - hs0), VW'(1));
        chk("valid_drop", VW'(vif.vec_valid), VW'(0));
        repeat (12) @(posedge clk);
        #1;
        chk("no_extra_hs", VW'(hs_cnt - hs0), VW'(1));
        vif.vec_ready = 1'b1;
        wait_done(100);

        // Start while busy, in FILL, in PRESENT and together with a handshake.
        vif.vec_ready = 1'b0;
        pulse_start(32'h0, 32'd3);
        repeat (3) @(posedge clk);
        #1;
        seed = 32'hDEADBEEF; cycles = 32'd7; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        wait_valid(40);
        start = 1'b1;
        @(posedge clk); #1;
        vif.vec_ready = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done(200);
        repeat (3) @(posedge clk);
        #1;
        chk("start_not_queued", VW'(busy), VW'(0));

        // Asynchronous reset in the middle of FILL word 3.
        vif.vec_ready = 1'b0;
        pulse_start(32'h0, 32'd0);
        repeat (3) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("arst_valid", VW'(vif.vec_valid), VW'(0));
        chk("arst_busy", VW'(busy), VW'(0));
        chk("arst_done", VW'(done), VW'(0));
        chk("arst_data", vif.vec_data, {VW{1'b0}});
        chk("arst_idx", VW'(vif.vec_idx), VW'(0));
        sb_q.delete();
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        vif.vec_ready = 1'b1;
        pulse_start(32'h0, 32'd0);
        wait_done(100);
        chk("w0_after_rst", VW'(vif.vec_data[31:0]), VW'(32'h00003039));

        // Long reference run with random backpressure.
        rdy_rand = 1'b1;
        pulse_start(32'd3965395580, 32'd100);
        wait_done(4000);
        rdy_rand = 1'b0;

        $display("CHECKS %0d ERRORS %0d", chk_cnt, err_cnt);
        $finish;
    end

endmodule
